hilo_div_ctrl: RTL
==================

// Module: hilo_div_ctrl
// PURPOSE
//  Sequencer for the HI/LO unit of the pipelined MIPS core. Runs DIVU as a multicycle restoring divide,
//  one quotient bit per clock, on a private 64-bit remainder/quotient register. Commits the result to HI/LO.
//  Services MFHI/MFLO/MTHI/MTLO and stalls the EX stage while the divide is in flight.
// PARAMETERS
//  WIDTH    32         operand width; HI, LO and the step count are all WIDTH
//  FN_DIVU  6'b011011  funct code for DIVU
//  FN_MFHI  6'b010000  funct code for MFHI
//  FN_MTHI  6'b010001  funct code for MTHI
//  FN_MFLO  6'b010010  funct code for MFLO
//  FN_MTLO  6'b010011  funct code for MTLO
// PORTS
//  clk      in   1      clock, all state changes on the rising edge
//  reset    in   1      synchronous, active-high
//  op_valid in   1      EX stage presents a HI/LO-class instruction this cycle
//  op_fn    in   6      funct field of that instruction
//  rs_data  in   WIDTH  dividend for DIVU; write data for MTHI/MTLO
//  rt_data  in   WIDTH  divisor for DIVU
//  stall    out  1      EX must hold the instruction; combinational
//  rd_data  out  WIDTH  HI for MFHI, LO for MFLO, else 0; combinational
//  busy     out  1      divide in flight (state != IDLE)
//  hi       out  WIDTH  architectural HI
//  lo       out  WIDTH  architectural LO
// BEHAVIOUR
//  Reset
//   - State -> IDLE; hi, lo, rem_q[2*WIDTH-1:0], divisor and step counter all cleared to 0.
//   - Reset mid-divide aborts the divide; no partial result reaches HI/LO.
//  FSM states: IDLE, RUN, DONE
//   - IDLE -> RUN when op_valid and op_fn==FN_DIVU.
//     Same edge: rem_q <= {0, rs_data}; divisor <= rt_data; cnt <= 0.
//   - RUN: one step per clock; when cnt==WIDTH-1 the step completes and the state goes to DONE.
//   - DONE -> IDLE unconditionally. Same edge: hi <= rem_q[2W-1:W]; lo <= rem_q[W-1:0].
//  RUN step (per clock)
//   - s = rem_q << 1.
//   - t = {1'b0, s[2W-1:W]} - {1'b0, divisor}, computed W+1 bits wide.
//   - If t[W]==0: rem_q <= {t[W-1:0], s[W-1:1], 1'b1}.
//   - Else: rem_q <= {s[2W-1:W], s[W-1:1], 1'b0} (restore).
//   - cnt <= cnt + 1.
//  Divide by zero
//   - No special case. The algorithm naturally yields lo=32'hFFFFFFFF and hi=rs_data.
//  Latency
//   - DIVU accepted at edge E; steps on edges E+1..E+32; HI/LO written at edge E+33.
//   - busy is high in the cycles between E and E+33.
//  Other ops (IDLE only)
//   - MTHI: hi <= rs_data at the next edge. MTLO: lo <= rs_data at the next edge.
//   - MFHI/MFLO: rd_data = hi/lo in the same cycle.
//  stall
//   - stall = op_valid and busy and op_fn is one of {DIVU, MFHI, MFLO, MTHI, MTLO}.
//   - A stalled op has no effect; EX re-presents it and it executes in the first cycle busy==0.
//   - Unrecognised op_fn: stall=0, rd_data=0, no effect.
//   - DIVU issued while IDLE: stall=0 in its issue cycle (accepted, not held).
//  Simultaneous events
//   - reset has priority over every op.
//   - In DONE, an MF* op stalls and reads the new HI/LO in the following cycle.
// TESTING
//  - DIVU 100/7: lo=14, hi=2 after edge E+33; busy high for exactly 33 cycles.
//  - DIVU 32'hFFFFFFFF/1 -> lo=32'hFFFFFFFF, hi=0.
//  - DIVU 32'h80000000/32'h00000003 -> lo=32'h2AAAAAAA, hi=2.
//  - DIVU 1234/0 -> lo=32'hFFFFFFFF, hi=1234.
//  - MFLO issued at E+1 -> stall=1 through E+33; then rd_data=quotient, stall=0.
//  - MTHI 32'hDEADBEEF then MFHI -> rd_data=32'hDEADBEEF; MTLO during busy stalls and lo is unchanged.
//  - reset asserted at E+10 -> state IDLE, hi=lo=0, busy=0; new DIVU 9/3 afterwards gives lo=3, hi=0.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// HI/LO sequencer for the MIPS EX stage: multicycle restoring DIVU plus MFHI/MFLO/MTHI/MTLO,
// holding the EX stage while a divide is in flight.
module hilo_div_ctrl #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  FN_DIVU = 6'b011011,
  parameter logic [5:0]  FN_MFHI = 6'b010000,
  parameter logic [5:0]  FN_MTHI = 6'b010001,
  parameter logic [5:0]  FN_MFLO = 6'b010010,
  parameter logic [5:0]  FN_MTLO = 6'b010011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       op_fn,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   step;
  logic                 known_fn;

  // Trial subtract on the upper half of (rem_q << 1); the shifted-out top bit is discarded.
  assign trial = {1'b0, rem_q[2*WIDTH-2:WIDTH-1]} - {1'b0, div_q};
  assign step  = trial[WIDTH] ? {rem_q[2*WIDTH-2:WIDTH-1], rem_q[WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0],         rem_q[WIDTH-2:0], 1'b1};

  assign known_fn = op_fn inside {FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO};
  assign busy     = (state_q != IDLE);
  assign stall    = op_valid && busy && known_fn;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    rd_data = '0;
    if (op_valid && op_fn == FN_MFHI) rd_data = hi_q;
    else if (op_valid && op_fn == FN_MFLO) rd_data = lo_q;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (op_fn == FN_DIVU) begin
            rem_d   = {{WIDTH{1'b0}}, rs_data};
            div_d   = rt_data;
            cnt_d   = '0;
            state_d = RUN;
          end else if (op_fn == FN_MTHI) begin
            hi_d = rs_data;
          end else if (op_fn == FN_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      RUN: begin
        rem_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        hi_d    = rem_q[2*WIDTH-1:WIDTH];
        lo_d    = rem_q[WIDTH-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
